// File: rtl/icache_miss_mshr_array.sv
// ICache miss-handling array: merges duplicate line misses, issues one A request per
// entry, assembles multi-beat D data by source, and returns whole lines to the refill path.
//
// state  | meaning
// FREE   | entry unused, may be allocated
// WAIT_A | line allocated, A request not yet accepted
// WAIT_D | A accepted, collecting D beats (flushed entries drain silently)
// DONE   | line assembled, waiting for the refill consumer
module icache_miss_mshr_array #(
    parameter int N_MSHR = 4,
    parameter int ADDR_W = 48,
    parameter int BEAT_W = 256,
    parameter int BEATS  = 2,
    parameter int SRC_W  = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_paddr,
    output logic                     a_valid,
    input  logic                     a_ready,
    output logic [SRC_W-1:0]         a_source,
    output logic [ADDR_W-1:0]        a_address,
    input  logic                     d_valid,
    input  logic [2:0]               d_opcode,
    input  logic [SRC_W-1:0]         d_source,
    input  logic [BEAT_W-1:0]        d_data,
    input  logic                     d_corrupt,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ADDR_W-1:0]        resp_paddr,
    output logic [BEAT_W*BEATS-1:0]  resp_data,
    output logic                     resp_corrupt,
    input  logic                     flush,
    output logic                     busy
);
    localparam int IDX_W  = (N_MSHR > 1) ? $clog2(N_MSHR) : 1;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LINE_W = BEAT_W * BEATS;
    localparam int OFF    = $clog2(LINE_W / 8);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF) - 64'd1);
    localparam logic [SRC_W:0]    N_SRC    = (SRC_W + 1)'(N_MSHR);

    typedef enum logic [1:0] {FREE = 2'd0, WAIT_A = 2'd1, WAIT_D = 2'd2, DONE = 2'd3} ent_state_t;

    ent_state_t          state_q   [N_MSHR];
    ent_state_t          state_nxt [N_MSHR];
    logic [ADDR_W-1:0]   line_q    [N_MSHR];
    logic [CNT_W-1:0]    cnt_q     [N_MSHR];
    logic [LINE_W-1:0]   data_q    [N_MSHR];
    logic                corrupt_q [N_MSHR];
    logic                flushed_q [N_MSHR];

    logic                a_hold_q, r_hold_q;
    logic [IDX_W-1:0]    a_hold_idx_q, r_hold_idx_q;

    logic [ADDR_W-1:0]   req_line;
    logic                merge_hit, free_any, a_any, done_any;
    logic [IDX_W-1:0]    free_idx, a_low, r_low, a_sel, r_sel, d_idx;
    logic                alloc, a_fire, resp_fire, d_hit, d_last;

    assign req_line = req_paddr & ~OFF_MASK;

    always_comb begin
        merge_hit = 1'b0;
        free_any  = 1'b0;
        free_idx  = '0;
        a_any     = 1'b0;
        a_low     = '0;
        done_any  = 1'b0;
        r_low     = '0;
        busy      = 1'b0;
        // Walk downwards so the lowest matching index is the one left standing.
        for (int i = N_MSHR - 1; i >= 0; i--) begin
            if (state_q[i] != FREE && !flushed_q[i] && line_q[i] == req_line) merge_hit = 1'b1;
            if (state_q[i] == FREE) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
            if (state_q[i] == WAIT_A) begin
                a_any = 1'b1;
                a_low = IDX_W'(i);
            end
            if (state_q[i] == DONE) begin
                done_any = 1'b1;
                r_low    = IDX_W'(i);
            end
            if (state_q[i] != FREE) busy = 1'b1;
        end
    end

    // A presented-but-stalled winner is held so a lower entry cannot swap in mid-handshake.
    assign a_sel = (a_hold_q && state_q[a_hold_idx_q] == WAIT_A) ? a_hold_idx_q : a_low;
    assign r_sel = (r_hold_q && state_q[r_hold_idx_q] == DONE) ? r_hold_idx_q : r_low;

    assign req_ready    = !flush && (merge_hit || free_any);
    assign alloc        = req_valid && req_ready && !merge_hit;

    assign a_valid      = a_any && !flush;
    assign a_fire       = a_valid && a_ready;
    assign a_source     = a_valid ? SRC_W'(a_sel) : '0;
    assign a_address    = a_valid ? line_q[a_sel] : '0;

    assign resp_valid   = done_any && !flush;
    assign resp_fire    = resp_valid && resp_ready;
    assign resp_paddr   = resp_valid ? line_q[r_sel] : '0;
    assign resp_data    = resp_valid ? data_q[r_sel] : '0;
    assign resp_corrupt = resp_valid ? corrupt_q[r_sel] : 1'b0;

    assign d_idx  = d_source[IDX_W-1:0];
    assign d_hit  = d_valid && d_opcode == 3'd1 && ({1'b0, d_source} < N_SRC) && state_q[d_idx] == WAIT_D;
    assign d_last = cnt_q[d_idx] == CNT_W'(BEATS - 1);

    always_comb begin
        for (int i = 0; i < N_MSHR; i++) begin
            state_nxt[i] = state_q[i];
            unique case (state_q[i])
                FREE:    if (alloc && free_idx == IDX_W'(i)) state_nxt[i] = WAIT_A;
                WAIT_A:  if (flush) state_nxt[i] = FREE;
                         else if (a_fire && a_sel == IDX_W'(i)) state_nxt[i] = WAIT_D;
                WAIT_D:  if (d_hit && d_idx == IDX_W'(i) && d_last)
                             state_nxt[i] = (flushed_q[i] || flush) ? FREE : DONE;
                DONE:    if (flush) state_nxt[i] = FREE;
                         else if (resp_fire && r_sel == IDX_W'(i)) state_nxt[i] = FREE;
                default: state_nxt[i] = FREE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_MSHR; i++) state_q[i] <= FREE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_MSHR; i++) begin
                line_q[i]    <= '0;
                cnt_q[i]     <= '0;
                data_q[i]    <= '0;
                corrupt_q[i] <= 1'b0;
                flushed_q[i] <= 1'b0;
            end
            a_hold_q     <= 1'b0;
            a_hold_idx_q <= '0;
            r_hold_q     <= 1'b0;
            r_hold_idx_q <= '0;
        end else begin
            for (int i = 0; i < N_MSHR; i++) begin
                if (alloc && free_idx == IDX_W'(i)) begin
                    line_q[i]    <= req_line;
                    cnt_q[i]     <= '0;
                    corrupt_q[i] <= 1'b0;
                    flushed_q[i] <= 1'b0;
                end
                if (flush && state_q[i] == WAIT_D) flushed_q[i] <= 1'b1;
                if (d_hit && d_idx == IDX_W'(i)) begin
                    for (int k = 0; k < BEATS; k++) begin
                        if (cnt_q[i] == CNT_W'(k)) data_q[i][k*BEAT_W +: BEAT_W] <= d_data;
                    end
                    cnt_q[i]     <= cnt_q[i] + CNT_W'(1);
                    corrupt_q[i] <= corrupt_q[i] | d_corrupt;
                end
            end
            a_hold_q     <= a_valid && !a_ready;
            a_hold_idx_q <= a_sel;
            r_hold_q     <= resp_valid && !resp_ready;
            r_hold_idx_q <= r_sel;
        end
    end
endmodule

// File: tb/tb_icache_miss_mshr_array.sv
// Randomised and directed bench for icache_miss_mshr_array against a line-level
// behavioural model of the miss entries.
module tb_icache_miss_mshr_array;
    localparam int N = 4, AW = 48, BW = 256, BT = 2, SW = 4, LW = BW * BT;

    logic clock = 1'b0, reset = 1'b0;
    always #5 clock = ~clock;

    logic          req_valid, req_ready, a_valid, a_ready, d_valid, d_corrupt;
    logic          resp_valid, resp_ready, resp_corrupt, flush, busy;
    logic [AW-1:0] req_paddr, a_address, resp_paddr;
    logic [SW-1:0] a_source, d_source;
    logic [2:0]    d_opcode;
    logic [BW-1:0] d_data;
    logic [LW-1:0] resp_data;

    icache_miss_mshr_array #(.N_MSHR(N), .ADDR_W(AW), .BEAT_W(BW), .BEATS(BT), .SRC_W(SW)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_paddr(req_paddr), .a_valid(a_valid), .a_ready(a_ready), .a_source(a_source),
        .a_address(a_address), .d_valid(d_valid), .d_opcode(d_opcode), .d_source(d_source),
        .d_data(d_data), .d_corrupt(d_corrupt), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_paddr(resp_paddr), .resp_data(resp_data), .resp_corrupt(resp_corrupt),
        .flush(flush), .busy(busy));

    // stimulus shadows, applied on the falling edge
    logic          drv_req_valid, drv_a_ready, drv_d_valid, drv_d_corrupt, drv_resp_ready, drv_flush;
    logic [AW-1:0] drv_req_paddr;
    logic [SW-1:0] drv_d_source;
    logic [2:0]    drv_d_opcode;
    logic [BW-1:0] drv_d_data;

    int checks = 0, errors = 0;

    // model: 0 free, 1 awaiting A, 2 collecting D, 3 line ready
    int            m_st [N];
    logic [AW-1:0] m_line [N];
    int            m_nb [N];
    logic [LW-1:0] m_buf [N];
    bit            m_cor [N], m_fl [N];
    bit            m_ahold, m_rhold;
    int            m_aidx, m_ridx;
    logic [SW-1:0] a_seen [$];

    task automatic chk(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int e = 0; e < N; e++) begin
            m_st[e] = 0; m_line[e] = '0; m_nb[e] = 0; m_buf[e] = '0; m_cor[e] = 0; m_fl[e] = 0;
        end
        m_ahold = 0; m_rhold = 0; m_aidx = 0; m_ridx = 0;
    endtask

    function automatic bit m_busy();
        for (int e = 0; e < N; e++) if (m_st[e] != 0) return 1;
        return 0;
    endfunction

    function automatic logic [BW-1:0] rnd_beat();
        logic [BW-1:0] r;
        for (int i = 0; i < BW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic idle();
        drv_req_valid = 0; drv_req_paddr = '0; drv_flush = 0;
        drv_d_valid = 0; drv_d_opcode = 3'd1; drv_d_source = '0; drv_d_data = '0; drv_d_corrupt = 0;
        drv_a_ready = 1; drv_resp_ready = 1;
    endtask

    task automatic dbeat(int src, logic [BW-1:0] data, bit cor, int op);
        drv_d_valid = 1; drv_d_source = SW'(src); drv_d_data = data; drv_d_corrupt = cor; drv_d_opcode = 3'(op);
    endtask

    task automatic req(logic [AW-1:0] pa);
        drv_req_valid = 1; drv_req_paddr = pa;
    endtask

    // One clock: apply stimulus, compare DUT outputs with the model, advance the model.
    task automatic cyc();
        logic [AW-1:0] ln;
        int fr, aw, rw, s;
        bit mg, bz, rr, av, rv, alloc, dhit;
        int ost [N];
        bit ofl [N];
        @(negedge clock);
        req_valid = drv_req_valid; req_paddr = drv_req_paddr; flush = drv_flush;
        a_ready = drv_a_ready; resp_ready = drv_resp_ready;
        d_valid = drv_d_valid; d_opcode = drv_d_opcode; d_source = drv_d_source;
        d_data = drv_d_data; d_corrupt = drv_d_corrupt;
        #1;
        ln = req_paddr & ~AW'(63);
        mg = 0; fr = -1; aw = -1; rw = -1; bz = 0;
        for (int e = 0; e < N; e++) begin
            if (m_st[e] != 0) bz = 1;
            if (m_st[e] != 0 && !m_fl[e] && m_line[e] == ln) mg = 1;
            if (m_st[e] == 0 && fr < 0) fr = e;
            if (m_st[e] == 1 && aw < 0) aw = e;
            if (m_st[e] == 3 && rw < 0) rw = e;
        end
        if (m_ahold && m_st[m_aidx] == 1) aw = m_aidx;
        if (m_rhold && m_st[m_ridx] == 3) rw = m_ridx;
        rr = !flush && (mg || fr >= 0);
        av = !flush && aw >= 0;
        rv = !flush && rw >= 0;
        chk("req_ready", req_ready, rr);
        chk("a_valid", a_valid, av);
        chk("resp_valid", resp_valid, rv);
        chk("busy", busy, bz);
        if (av) begin
            chk("a_source", a_source, SW'(aw));
            chk("a_address", a_address, m_line[aw]);
        end
        if (rv) begin
            chk("resp_paddr", resp_paddr, m_line[rw]);
            chk("resp_data", resp_data, m_buf[rw]);
            chk("resp_corrupt", resp_corrupt, m_cor[rw]);
        end
        if (a_valid && a_ready) a_seen.push_back(a_source);
        alloc = req_valid && rr && !mg;
        dhit = 0;
        s = int'(d_source);
        if (d_valid && d_opcode == 3'd1 && s < N) dhit = (m_st[s] == 2);
        for (int e = 0; e < N; e++) begin ost[e] = m_st[e]; ofl[e] = m_fl[e]; end
        for (int e = 0; e < N; e++) if (flush) begin
            if (ost[e] == 1 || ost[e] == 3) m_st[e] = 0;
            if (ost[e] == 2) m_fl[e] = 1;
        end
        if (av && a_ready) m_st[aw] = 2;
        if (rv && resp_ready) m_st[rw] = 0;
        if (dhit) begin
            m_buf[s][m_nb[s]*BW +: BW] = d_data;
            m_nb[s]++;
            m_cor[s] = m_cor[s] | d_corrupt;
            if (m_nb[s] == BT) begin
                m_nb[s] = 0;
                m_st[s] = (ofl[s] || flush) ? 0 : 3;
            end
        end
        if (alloc) begin
            m_st[fr] = 1; m_line[fr] = ln; m_nb[fr] = 0; m_buf[fr] = '0; m_cor[fr] = 0; m_fl[fr] = 0;
        end
        m_ahold = av && !a_ready; m_aidx = aw;
        m_rhold = rv && !resp_ready; m_ridx = rw;
    endtask

    task automatic drain();
        for (int c = 0; c < 300; c++) begin
            idle();
            for (int e = N - 1; e >= 0; e--) if (m_st[e] == 2) dbeat(e, rnd_beat(), 0, 1);
            cyc();
            if (!m_busy() && !busy) break;
        end
        chk("drain_idle", busy, 0);
    endtask

    logic [BW-1:0] ba, bb, b0a, b0b;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        idle();
        req_valid = 0; req_paddr = '0; flush = 0; a_ready = 0; resp_ready = 0;
        d_valid = 0; d_opcode = 0; d_source = '0; d_data = '0; d_corrupt = 0;
        m_reset();
        repeat (3) @(negedge clock);
        reset = 1;

        // reset state
        idle(); cyc();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_resp_data", resp_data, 0);

        // single miss
        req(48'h1000_0044); cyc();
        chk("sm_accept", req_ready, 1);
        idle(); cyc();
        chk("sm_a_address", a_address, 48'h1000_0040);
        chk("sm_a_source", a_source, 0);
        ba = rnd_beat(); bb = rnd_beat();
        idle(); dbeat(0, ba, 0, 1); cyc();
        idle(); dbeat(0, bb, 0, 1); cyc();
        chk("sm_no_early_resp", resp_valid, 0);
        idle(); cyc();
        chk("sm_resp_valid", resp_valid, 1);
        chk("sm_resp_data", resp_data, {bb, ba});
        chk("sm_resp_corrupt", resp_corrupt, 0);
        idle(); cyc();
        chk("sm_free_after", busy, 0);

        // merge / full
        idle(); drv_a_ready = 0;
        for (int k = 0; k < 4; k++) begin req(48'h2000_0000 + AW'(k * 256 + 5)); cyc(); end
        req(48'h2000_0400); cyc();
        chk("full_stall", req_ready, 0);
        req(48'h2000_0213); cyc();
        chk("merge_accept", req_ready, 1);
        a_seen.delete();
        idle();
        repeat (8) cyc();
        chk("merge_a_count", a_seen.size(), 4);
        for (int k = 0; k < 4 && k < a_seen.size(); k++) chk("merge_a_src", a_seen[k], SW'(k));
        drain();

        // out-of-order D, corrupt, ignored opcode
        idle(); drv_resp_ready = 0;
        req(48'h3000_0000); cyc();
        req(48'h3000_0040); cyc();
        req(48'h3000_0080); cyc();
        drv_req_valid = 0; cyc();
        dbeat(2, rnd_beat(), 0, 1); cyc();
        dbeat(0, rnd_beat(), 0, 1); cyc();
        dbeat(0, rnd_beat(), 1, 0); cyc();
        dbeat(0, rnd_beat(), 0, 1); cyc();
        dbeat(2, rnd_beat(), 1, 1); cyc();
        idle(); cyc();
        chk("ooo_first_paddr", resp_paddr, 48'h3000_0000);
        chk("ooo_first_corrupt", resp_corrupt, 0);
        cyc();
        chk("ooo_second_paddr", resp_paddr, 48'h3000_0080);
        chk("ooo_second_corrupt", resp_corrupt, 1);
        drain();

        // response backpressure
        idle(); drv_resp_ready = 0;
        req(48'h4000_0000); cyc();
        req(48'h4000_0040); cyc();
        req(48'h4000_0080); cyc();
        drv_req_valid = 0; cyc();
        b0a = rnd_beat(); b0b = rnd_beat();
        dbeat(0, b0a, 0, 1); cyc();
        dbeat(0, b0b, 0, 1); cyc();
        dbeat(1, rnd_beat(), 0, 1); cyc();
        dbeat(1, rnd_beat(), 0, 1); cyc();
        for (int c = 0; c < 10; c++) begin
            drv_d_valid = 0;
            if (c == 2 || c == 5) dbeat(2, rnd_beat(), 0, 1);
            cyc();
            chk("bp_hold_valid", resp_valid, 1);
            chk("bp_hold_paddr", resp_paddr, 48'h4000_0000);
            chk("bp_hold_data", resp_data, {b0b, b0a});
        end
        idle(); cyc();
        chk("bp_resp0", resp_paddr, 48'h4000_0000);
        cyc();
        chk("bp_resp1", resp_paddr, 48'h4000_0040);
        cyc();
        chk("bp_resp2", resp_paddr, 48'h4000_0080);
        drain();

        // flush with entries in WAIT_A, WAIT_D and DONE
        idle();
        req(48'h5000_0000); cyc();
        req(48'h5000_0040); cyc();
        req(48'h5000_0080); cyc();
        drv_req_valid = 0; cyc();
        dbeat(0, rnd_beat(), 0, 1); cyc();
        dbeat(0, rnd_beat(), 0, 1); cyc();
        idle(); cyc();
        drv_resp_ready = 0;
        dbeat(2, rnd_beat(), 0, 1); cyc();
        dbeat(2, rnd_beat(), 0, 1); cyc();
        dbeat(1, rnd_beat(), 0, 1); cyc();
        drv_d_valid = 0; drv_a_ready = 0;
        req(48'h5000_00c0); cyc();
        req(48'h5000_0100); drv_flush = 1; drv_a_ready = 1; drv_resp_ready = 1; cyc();
        chk("fl_a_masked", a_valid, 0);
        chk("fl_resp_masked", resp_valid, 0);
        chk("fl_req_blocked", req_ready, 0);
        idle(); cyc();
        chk("fl_draining_busy", busy, 1);
        chk("fl_no_a_after", a_valid, 0);
        dbeat(1, rnd_beat(), 0, 1); cyc();
        idle(); cyc();
        chk("fl_silent_drain", resp_valid, 0);
        chk("fl_idle", busy, 0);

        // randomised traffic
        for (int c = 0; c < 3000; c++) begin
            int wd [$];
            idle();
            drv_req_valid = 1'($urandom_range(0, 1));
            drv_req_paddr = 48'h6000_0000 + AW'($urandom_range(0, 7) * 64 + $urandom_range(0, 63));
            drv_a_ready = ($urandom_range(0, 9) < 7);
            drv_resp_ready = ($urandom_range(0, 9) < 6);
            drv_flush = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 9) < 6) begin
                for (int e = 0; e < N; e++) if (m_st[e] == 2) wd.push_back(e);
                if (wd.size() > 0 && $urandom_range(0, 9) < 8)
                    dbeat(wd[$urandom_range(0, wd.size() - 1)], rnd_beat(), ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 7) == 0) ? 0 : 1);
                else
                    dbeat($urandom_range(0, 15), rnd_beat(), 0, 1);
            end
            cyc();
        end
        drain();

        // asynchronous reset mid-burst
        idle();
        req(48'h7000_0080); cyc();
        idle(); cyc();
        dbeat(0, rnd_beat(), 0, 1); cyc();
        @(posedge clock); #2;
        reset = 0;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_a_valid", a_valid, 0);
        chk("ar_resp_valid", resp_valid, 0);
        chk("ar_resp_data", resp_data, 0);
        m_reset();
        @(negedge clock);
        idle();
        req_valid = 0; flush = 0; d_valid = 0;
        reset = 1;
        dbeat(0, rnd_beat(), 0, 1); cyc();
        idle(); drv_a_ready = 0; cyc();
        chk("ar_late_beat_ignored", busy, 0);
        req(48'h7100_0000); cyc();
        idle(); drv_a_ready = 0; cyc();
        chk("ar_realloc_valid", a_valid, 1);
        chk("ar_realloc_src", a_source, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/icache_miss_mshr_array.md
Name: icache_miss_mshr_array

Overview:
Parametrised ICache miss-handling array. It accepts line-miss requests, merges duplicates, and allocates one of N_MSHR entries. Each entry issues one TileLink-style A request, collects multi-beat D data tagged by source, and returns the assembled cache line to the ICache refill path. It replaces the fixed two-entry fetch/prefetch miss path and adds configurable depth, beat count, request merging and flush-drain behaviour.

Parameters:
N_MSHR, 4, number of miss entries (2..16)
ADDR_W, 48, physical address width
BEAT_W, 256, D-channel data beat width in bits
BEATS, 2, beats per cache line (power of 2); line = BEAT_W*BEATS bits
SRC_W, 4, A/D source width; must be >= clog2(N_MSHR)

Ports:
clock  in  1  clock
reset  in  1  asynchronous reset, active-low
req_valid  in  1  miss request valid
req_ready  out  1  miss request accepted when valid&ready
req_paddr  in  ADDR_W  miss physical address, any byte offset
a_valid  out  1  A-channel request valid
a_ready  in  1  A-channel ready
a_source  out  SRC_W  entry index, zero-extended
a_address  out  ADDR_W  line-aligned address
d_valid  in  1  D beat valid; always accepted, no ready
d_opcode  in  3  D opcode; only 3'd1 (data) is consumed
d_source  in  SRC_W  entry index
d_data  in  BEAT_W  beat data
d_corrupt  in  1  beat corrupt flag
resp_valid  out  1  refill line valid
resp_ready  in  1  refill consumer ready
resp_paddr  out  ADDR_W  line-aligned address
resp_data  out  BEAT_W*BEATS  line; beat k is at bits [k*BEAT_W +: BEAT_W]
resp_corrupt  out  1  OR of all beat corrupt flags for the line
flush  in  1  fence.i / redirect flush, single-cycle pulse
busy  out  1  any entry not FREE

Behaviour:
- Line offset bits OFF = clog2(BEAT_W*BEATS/8). Line address = paddr with low OFF bits zeroed. All address compares use the line address.
- Per-entry state: FREE, WAIT_A, WAIT_D, DONE. Per-entry fields: line address, beat counter (clog2(BEATS) bits, wraps), data buffer, corrupt flag, flushed flag.
- Reset (reset=0, asynchronous): all entries FREE, counters, flags and buffers cleared. a_valid=0, resp_valid=0, resp_data=0, resp_corrupt=0, busy=0. req_ready=1 once reset is released.
- Request path:
  - Merge: if the request line matches any entry that is not FREE and not flushed, req_ready=1 and no allocation occurs.
  - Allocate: otherwise, if any entry is FREE, the lowest-index FREE entry is allocated and moves to WAIT_A on the next edge; req_ready=1.
  - Stall: otherwise req_ready=0.
  - req_ready=0 in any cycle where flush=1.
- A channel: a_valid = any entry in WAIT_A. The lowest index wins and is presented on a_source/a_address. The value is stable while a_ready=0. On a_valid&a_ready the entry moves to WAIT_D. An accepted request appears on A one cycle after acceptance at the earliest.
- D channel: a beat is consumed when d_valid & d_opcode==1 & d_source<N_MSHR & entry[d_source] is in WAIT_D. The beat is written to slice [beat counter], the counter increments, and corrupt is ORed in. On the final beat (counter==BEATS-1) the entry moves to DONE, or to FREE if flushed. All other D beats are ignored.
- Response: resp_valid = any DONE entry; the lowest index wins. Outputs stay stable until resp_ready. On fire the entry moves to FREE and can be reallocated the next cycle. The final D beat at edge T gives resp_valid in cycle T+1 at the earliest.
- Flush, on the cycle flush=1:
  - WAIT_A entries become FREE, including one handshaking on A that cycle; that handshake is suppressed because a_valid is masked by flush.
  - WAIT_D entries set flushed, keep draining D, then free silently.
  - DONE entries become FREE; resp_valid is masked to 0 that cycle.
- Simultaneous events:
  - An allocation and a D final-beat on different entries both take effect.
  - A resp fire that frees entry i and an allocation in the same cycle: the allocator sees the pre-edge state and does not pick entry i.
  - A request matching an entry whose resp fires that cycle is merged; no allocation. The consumer is responsible for the hit.
- busy = OR over entries of (state != FREE).

Test Plan:
- Single miss: req_paddr=0x1000_0044, a_ready=1; D beats src0 data A then B → a_address=0x1000_0040, a_source=0; resp_valid 1 cycle after beat 2, resp_data={B,A}, resp_corrupt=0, entry FREE after fire.
- Merge/full: 4 distinct lines then a 5th with a_ready=0 → req_ready=0 for the 5th. Repeat line 2 → accepted with no new A request. Only 4 A requests are issued, sources 0..3.
- Out-of-order D: sources 2,0 interleaved, second beat of src2 corrupt=1 → two responses, lowest DONE index first; src2 resp_corrupt=1; opcode 0 beats ignored.
- Backpressure: resp_ready=0 for 10 cycles with 2 lines DONE → resp_valid held, resp_paddr/resp_data stable; D for other entries still absorbed.
- Flush: entry0 WAIT_A, entry1 WAIT_D (1 of 2 beats), entry2 DONE, flush pulse → no A for entry0, resp_valid=0. Entry1 drains its remaining beat with no resp; busy=0 afterwards.
- Async reset asserted mid-D-burst → outputs 0 immediately. After release, a late D beat is ignored and new requests allocate entry0.
